// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: control encodings, operation field
// values, sequencer state encoding and the default datapath width.
// Latency: n/a (definitions only). Backpressure: n/a.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 32;

    // Full 4-bit control codes: {a_invert, b_invert, op[1:0]}
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    // Operation field values selecting the slice output
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef struct packed {
        logic       a_invert;
        logic       b_invert;
        logic [1:0] op;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/alu_serial_slice.sv
// One-bit ALU slice: optional operand inversion, AND/OR/ADD/LESS select, carry chain.
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
// Ports: a/b operand bits, a_invert/b_invert, op select, cin/less in; result, cout, set (raw sum), overflow (cin^cout) out.
module alu_serial_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic [1:0] op,
    input  logic       cin,
    input  logic       less,
    output logic       result,
    output logic       cout,
    output logic       set,
    output logic       overflow
);

    logic a_eff;
    logic b_eff;
    logic sum;

    always_comb begin
        a_eff    = a ^ a_invert;
        b_eff    = b ^ b_invert;
        sum      = a_eff ^ b_eff ^ cin;
        cout     = (a_eff & b_eff) | (cin & (a_eff ^ b_eff));
        set      = sum;
        // Only meaningful at the MSB, where carry-in != carry-out flags signed overflow
        overflow = cin ^ cout;
        result   = 1'b0;
        case (op)
            OP_AND:  result = a_eff & b_eff;
            OP_OR:   result = a_eff | b_eff;
            OP_ADD:  result = sum;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU sequencer: runs one alu_serial_slice over WIDTH cycles, LSB first.
// Latency: done_o rises WIDTH+1 edges after the accept edge; busy_o covers that span.
// Backpressure: start_i is only accepted in IDLE; requests while busy are dropped, not queued.
// Ports: clk_i, rst_i (sync, active-high); start_i, src1_i, src2_i, ctrl_i in;
//        busy_o, done_o, result_o, zero_o, cout_o, overflow_o out (held between done pulses).
// Optional: define ALU_SERIAL_TRACE_EN to print each completed operation in simulation.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int IDX_W = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic             accept;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    ctrl_t            ctrl_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             msb_cout_q;
    logic             msb_ovf_q;
    logic             msb_set_q;
    logic             last_bit;
    logic [WIDTH-1:0] final_result;

    logic             slice_result;
    logic             slice_cout;
    logic             slice_set;
    logic             slice_ovf;

    alu_serial_slice u_slice (
        .a        (a_sr[0]),
        .b        (b_sr[0]),
        .a_invert (ctrl_q.a_invert),
        .b_invert (ctrl_q.b_invert),
        .op       (ctrl_q.op),
        .cin      (carry_q),
        .less     (1'b0),
        .result   (slice_result),
        .cout     (slice_cout),
        .set      (slice_set),
        .overflow (slice_ovf)
    );

    assign last_bit = (idx_q == IDX_W'(WIDTH - 1));
    assign busy_o   = (state_q != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_bit) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // SLT is resolved only once the MSB has been seen; the serial chain itself feeds less=0
    always_comb begin
        final_result = res_sr;
        if (ctrl_q.op == OP_LESS) begin
            final_result = {{(WIDTH-1){1'b0}}, msb_set_q};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            ctrl_q     <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            msb_cout_q <= 1'b0;
            msb_ovf_q  <= 1'b0;
            msb_set_q  <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (accept) begin
                a_sr    <= src1_i;
                b_sr    <= src2_i;
                ctrl_q  <= ctrl_t'(ctrl_i);
                idx_q   <= '0;
                // Seeding carry with b_invert turns ~B into -B for SUB/SLT
                carry_q <= ctrl_i[2];
            end
            if (state_q == ST_RUN) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                // Result bits enter at the top so bit 0 ends at position 0 after WIDTH shifts
                res_sr  <= {slice_result, res_sr[WIDTH-1:1]};
                carry_q <= slice_cout;
                idx_q   <= idx_q + IDX_W'(1);
                if (last_bit) begin
                    msb_cout_q <= slice_cout;
                    msb_ovf_q  <= slice_ovf;
                    // Sign of the difference corrected for overflow gives true signed less-than
                    msb_set_q  <= slice_set ^ slice_ovf;
                end
            end
            if (state_q == ST_FINISH) begin
                result_o   <= final_result;
                zero_o     <= (final_result == '0);
                cout_o     <= ctrl_q.op[1] & msb_cout_q;
                overflow_o <= ctrl_q.op[1] & msb_ovf_q;
                done_o     <= 1'b1;
            end
        end
    end

`ifdef ALU_SERIAL_TRACE_EN
    logic [WIDTH-1:0] trace_a_q;
    logic [WIDTH-1:0] trace_b_q;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            trace_a_q <= src1_i;
            trace_b_q <= src2_i;
        end
    end

    always @(posedge clk_i) begin
        if (done_o) begin
            $display("alu_serial: ctrl=%b a=%h b=%h result=%h ovf=%b set=%b cout=%b",
                     ctrl_q, trace_a_q, trace_b_q, result_o, overflow_o, msb_set_q, cout_o);
        end
    end
`endif

endmodule

// File: tb/tb_alu_serial.sv
module tb_alu_serial;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    typedef struct {
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [W-1:0] src1_i = '0;
    logic [W-1:0] src2_i = '0;
    logic [3:0]   ctrl_i = '0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         cout_o;
    logic         overflow_o;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    exp_t sb_q[$];
    vec_t tbl[10];

    alu_serial #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .ctrl_i     (ctrl_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .cout_o     (cout_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, overflow from operand/result signs
    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         r;
        logic [W-1:0] aa;
        logic [W-1:0] bb;
        logic [W:0]   s;
        logic         ovf;
        logic         set;
        aa  = c[3] ? ~a : a;
        bb  = c[2] ? ~b : b;
        s   = {1'b0, aa} + {1'b0, bb} + (W+1)'(c[2]);
        ovf = (aa[W-1] == bb[W-1]) && (s[W-1] != aa[W-1]);
        set = s[W-1] ^ ovf;
        case (c[1:0])
            2'b00:   r.res = aa & bb;
            2'b01:   r.res = aa | bb;
            2'b10:   r.res = s[W-1:0];
            default: r.res = {{(W-1){1'b0}}, set};
        endcase
        r.cout = c[1] & s[W];
        r.ovf  = c[1] & ovf;
        r.zero = (r.res == '0);
        return r;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done_o && !rst_i) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(done_o), 64'(1'b0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", 64'(result_o), 64'(e.res));
                check("cout", 64'(cout_o), 64'(e.cout));
                check("overflow", 64'(overflow_o), 64'(e.ovf));
                check("zero", 64'(zero_o), 64'(e.zero));
                check("busy_at_done", 64'(busy_o), 64'(1'b0));
            end
        end
    end

    // Drive one start pulse at a negedge; returns at the negedge after the accept edge
    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input bit push);
        @(negedge clk);
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        start_i = 1'b1;
        if (push) sb_q.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Counts edges from the accept edge until done_o is seen
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done_o && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        if (!done_o) begin
            check("done_timeout", 64'(edges), 64'(W + 1));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges;
        int   c0;
        exp_t e;
        exp_t dummy;
        logic [W-1:0] held;

        tbl[0] = '{CTRL_ADD, 32'h7FFFFFFF, 32'h00000001, '{32'h80000000, 1'b0, 1'b1, 1'b0}};
        tbl[1] = '{CTRL_SUB, 32'h00000005, 32'h00000005, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        tbl[2] = '{CTRL_SLT, 32'hFFFFFFFD, 32'h00000002, '{32'h00000001, 1'b1, 1'b0, 1'b0}};
        tbl[3] = '{CTRL_SLT, 32'h7FFFFFFF, 32'h80000000, '{32'h00000000, 1'b0, 1'b1, 1'b1}};
        tbl[4] = '{CTRL_NOR, 32'h0F0F0F0F, 32'h00FF00FF, '{32'hF000F000, 1'b0, 1'b0, 1'b0}};
        tbl[5] = '{CTRL_AND, 32'hF0F0F0F0, 32'hFF00FF00, '{32'hF000F000, 1'b0, 1'b0, 1'b0}};
        tbl[6] = '{CTRL_OR,  32'h0F0F0000, 32'h0000F0F0, '{32'h0F0FF0F0, 1'b0, 1'b0, 1'b0}};
        tbl[7] = '{CTRL_ADD, 32'hFFFFFFFF, 32'h00000001, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        tbl[8] = '{CTRL_SUB, 32'h80000000, 32'h00000001, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
        tbl[9] = '{CTRL_AND, 32'hAAAAAAAA, 32'h55555555, '{32'h00000000, 1'b0, 1'b0, 1'b1}};
        dummy = '{32'h0, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_result", 64'(result_o), 64'(0));
        check("rst_zero", 64'(zero_o), 64'(0));
        check("rst_cout", 64'(cout_o), 64'(0));
        check("rst_overflow", 64'(overflow_o), 64'(0));

        // First op: latency, busy during run, outputs stable during run
        issue(tbl[0].ctrl, tbl[0].a, tbl[0].b, tbl[0].e, 1'b1);
        check("busy_after_accept", 64'(busy_o), 64'(1));
        held = result_o;
        repeat (10) @(negedge clk);
        check("result_stable_in_run", 64'(result_o), 64'(held));
        wait_done(edges);
        check("latency_first", 64'(edges + 10), 64'(W + 1));

        // Table-driven vectors
        for (int i = 1; i < 10; i++) begin
            issue(tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].e, 1'b1);
            wait_done(edges);
            check("latency_tbl", 64'(edges), 64'(W + 1));
        end

        // Random vectors, every ctrl code executed literally
        for (int i = 0; i < 8; i++) begin
            logic [3:0]   c;
            logic [W-1:0] a;
            logic [W-1:0] b;
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            e = model(c, a, b);
            issue(c, a, b, e, 1'b1);
            wait_done(edges);
        end

        // start_i while busy is ignored
        e = model(CTRL_SUB, 32'h00001234, 32'h00000234);
        issue(CTRL_SUB, 32'h00001234, 32'h00000234, e, 1'b1);
        c0 = done_cnt;
        repeat (5) @(negedge clk);
        ctrl_i  = CTRL_OR;
        src1_i  = 32'hDEAD0000;
        src2_i  = 32'h0000BEEF;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_during_ignored_start", 64'(busy_o), 64'(1));
        wait_done(edges);
        repeat (40) @(negedge clk);
        check("single_done_ignored_start", 64'(done_cnt), 64'(c0 + 1));

        // Reset at cycle 10 of RUN aborts without done; previous result (0x1000) is cleared
        issue(CTRL_ADD, 32'h11111111, 32'h22222222, dummy, 1'b0);
        c0 = done_cnt;
        repeat (9) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("abort_busy", 64'(busy_o), 64'(0));
        check("abort_result", 64'(result_o), 64'(0));
        check("abort_done", 64'(done_o), 64'(0));
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(c0));
        e = model(CTRL_ADD, 32'h11111111, 32'h22222222);
        issue(CTRL_ADD, 32'h11111111, 32'h22222222, e, 1'b1);
        wait_done(edges);
        check("latency_after_abort", 64'(edges), 64'(W + 1));

        // Back-to-back: start held high across done
        @(negedge clk);
        e = model(CTRL_SLT, 32'h00000003, 32'h00000009);
        ctrl_i  = CTRL_SLT;
        src1_i  = 32'h00000003;
        src2_i  = 32'h00000009;
        start_i = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        c0 = done_cnt;
        wait_done(edges);
        check("latency_b2b_first", 64'(edges), 64'(W + 1));
        e = model(CTRL_NOR, 32'h12345678, 32'h0F0F0F0F);
        ctrl_i = CTRL_NOR;
        src1_i = 32'h12345678;
        src2_i = 32'h0F0F0F0F;
        sb_q.push_back(e);
        @(negedge clk);
        check("b2b_accept_after_done", 64'(busy_o), 64'(1));
        start_i = 1'b0;
        wait_done(edges);
        check("latency_b2b_second", 64'(edges), 64'(W + 1));
        repeat (5) @(negedge clk);
        check("b2b_done_count", 64'(done_cnt), 64'(c0 + 2));

        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
